// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single memory port between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). Exactly one transaction is in flight at a time:
// accept one request (IDLE), present it downstream until memory takes it
// (ISSUE), then wait for the response and route it to the owner (WAIT).
//
// Handshake semantics (all request channels): a transfer happens in a cycle
// where valid and ready are both 1. Requesters hold valid and payload stable
// until ready. Response channels have no back-pressure: resp_valid is a
// single-cycle pulse and must be consumed when seen.
//
// Optional feature (compile-time macro MEM_ARBITER_RR_EN):
//   defined   - round-robin arbitration on simultaneous requests, tracked by
//               a last_grant register (resets to IFU).
//   undefined - fixed priority, LSU wins; no last_grant register exists.
//
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   ifu_req_valid/ready, ifu_addr      IFU fetch request channel
//   ifu_resp_valid, ifu_rdata          IFU fetch response (rdata 0 when idle)
//   lsu_req_valid/ready, lsu_addr,
//   lsu_w_en, lsu_wdata, lsu_mask      LSU load/store request channel
//   lsu_resp_valid, lsu_rdata          LSU response (rdata 0 for stores)
//   mem_req_valid/ready, mem_addr,
//   mem_w_en, mem_wdata, mem_mask      registered request to the memory bridge
//   mem_resp_valid, mem_rdata          memory response
//   busy                               high whenever state is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_w_en,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_mask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_mask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Owner of the in-flight transaction: 0 = IFU, 1 = LSU.
    logic owner_lsu;

    logic req_any;
    logic grant_lsu;
    logic accept;

    assign req_any = ifu_req_valid | lsu_req_valid;
    assign accept  = (state == IDLE) && req_any;

`ifdef MEM_ARBITER_RR_EN
    // 0 = IFU was granted last, 1 = LSU was granted last.
    logic last_grant_lsu;

    // On a conflict the requester that did not win last time gets it;
    // a lone requester always wins.
    always_comb begin
        grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = ~last_grant_lsu;
        end else begin
            grant_lsu = lsu_req_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_lsu <= 1'b0;
        end else if (accept) begin
            last_grant_lsu <= grant_lsu;
        end
    end
`else
    // Fixed priority: the LSU wins whenever it is requesting.
    assign grant_lsu = lsu_req_valid;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture: the mem_* outputs come straight from these registers
    // so they stay stable for the whole ISSUE phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_lsu <= 1'b0;
            mem_addr  <= '0;
            mem_w_en  <= 1'b0;
            mem_wdata <= '0;
            mem_mask  <= '0;
        end else if (accept) begin
            owner_lsu <= grant_lsu;
            if (grant_lsu) begin
                mem_addr  <= lsu_addr;
                mem_w_en  <= lsu_w_en;
                mem_wdata <= lsu_wdata;
                mem_mask  <= lsu_mask;
            end else begin
                // Fetches are always full-word reads.
                mem_addr  <= ifu_addr;
                mem_w_en  <= 1'b0;
                mem_wdata <= '0;
                mem_mask  <= '1;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    ifu_req_ready = ~grant_lsu;
                    lsu_req_ready = grant_lsu;
                    state_nxt     = ISSUE;
                end
            end

            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = IDLE;
                    if (owner_lsu) begin
                        lsu_resp_valid = 1'b1;
                        // A store only needs the ack; its data bus reads 0.
                        lsu_rdata      = mem_w_en ? '0 : mem_rdata;
                    end else begin
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = mem_rdata;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_w_en = 1'b0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_mask = '0;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_w_en;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_mask;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_w_en(lsu_w_en), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_w_en(mem_w_en), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // ---------------------------------------------------------------------------
  // bookkeeping
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // scoreboard: bit DW = owner (1 = LSU), bits DW-1:0 = expected rdata
  // ---------------------------------------------------------------------------
  logic [DW:0] exp_q[$];

  always begin
    @(negedge clk);
    #3;
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got ifu_resp=%0b lsu_resp=%0b want no response (t=%0t)",
                 ifu_resp_valid, lsu_resp_valid, $time);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("sb_owner", {63'd0, lsu_resp_valid}, {63'd0, e[DW]});
        chk("sb_single_owner", {63'd0, ifu_resp_valid & lsu_resp_valid}, 64'd0);
        chk("sb_rdata", {32'd0, (lsu_resp_valid ? lsu_rdata : ifu_rdata)}, {32'd0, e[DW-1:0]});
        chk("sb_other_rdata", {32'd0, (lsu_resp_valid ? ifu_rdata : lsu_rdata)}, 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          ifu_v;
    logic [AW-1:0] ifu_a;
    logic          lsu_v;
    logic [AW-1:0] lsu_a;
    logic          lsu_w;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic          hold;      // keep the winner's valid high afterwards
    int            stall;     // cycles of mem_req_ready=0 in ISSUE
    int            wait_cyc;  // cycles before mem_resp_valid in WAIT
    logic [DW-1:0] rdata;     // what memory returns
    logic          exp_lsu;   // expected winner
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic iv, input logic [AW-1:0] ia, input logic lv,
                         input logic [AW-1:0] la, input logic lw, input logic [DW-1:0] wd,
                         input logic [MW-1:0] m, input logic hold, input int stall,
                         input int wc, input logic [DW-1:0] rd, input logic exp_lsu);
    vec_t v;
    v.ifu_v = iv; v.ifu_a = ia; v.lsu_v = lv; v.lsu_a = la; v.lsu_w = lw;
    v.wdata = wd; v.mask = m; v.hold = hold; v.stall = stall; v.wait_cyc = wc;
    v.rdata = rd; v.exp_lsu = exp_lsu;
    vecs.push_back(v);
  endtask

  // Called at the falling edge of the accept cycle (DUT in IDLE); returns at
  // the falling edge of the following IDLE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [AW-1:0] e_addr;
    logic          e_w;
    logic [DW-1:0] e_wdata;
    logic [MW-1:0] e_mask;
    logic [DW-1:0] e_rd;
    e_addr  = v.exp_lsu ? v.lsu_a : v.ifu_a;
    e_w     = v.exp_lsu & v.lsu_w;
    e_wdata = v.exp_lsu ? v.wdata : '0;
    e_mask  = v.exp_lsu ? v.mask : 4'hF;
    e_rd    = e_w ? '0 : v.rdata;

    // accept cycle
    ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
    lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_w_en = v.lsu_w;
    lsu_wdata = v.wdata; lsu_mask = v.mask;
    #1;
    chk($sformatf("v%0d_ifu_ready", idx), {63'd0, ifu_req_ready}, {63'd0, ~v.exp_lsu});
    chk($sformatf("v%0d_lsu_ready", idx), {63'd0, lsu_req_ready}, {63'd0, v.exp_lsu});
    chk($sformatf("v%0d_idle_busy", idx), {63'd0, busy}, 64'd0);
    exp_q.push_back({v.exp_lsu, e_rd});

    // issue phase, with optional stall and a spurious response
    @(negedge clk);
    if (!v.hold) begin
      if (v.exp_lsu) lsu_req_valid = 1'b0;
      else ifu_req_valid = 1'b0;
    end
    for (int s = 0; s <= v.stall; s++) begin
      mem_req_ready  = (s == v.stall);
      mem_resp_valid = (s == 1);
      mem_rdata      = 32'hBAD0_BAD0;
      #1;
      chk($sformatf("v%0d_mem_valid", idx), {63'd0, mem_req_valid}, 64'd1);
      chk($sformatf("v%0d_mem_addr", idx), {32'd0, mem_addr}, {32'd0, e_addr});
      chk($sformatf("v%0d_mem_w_en", idx), {63'd0, mem_w_en}, {63'd0, e_w});
      chk($sformatf("v%0d_mem_wdata", idx), {32'd0, mem_wdata}, {32'd0, e_wdata});
      chk($sformatf("v%0d_mem_mask", idx), {60'd0, mem_mask}, {60'd0, e_mask});
      chk($sformatf("v%0d_issue_ready", idx), {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      chk($sformatf("v%0d_issue_resp", idx), {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      chk($sformatf("v%0d_issue_busy", idx), {63'd0, busy}, 64'd1);
      @(negedge clk);
    end

    // wait phase
    mem_req_ready = 1'b0;
    for (int w = 0; w <= v.wait_cyc; w++) begin
      mem_resp_valid = (w == v.wait_cyc);
      mem_rdata      = (w == v.wait_cyc) ? v.rdata : '0;
      #1;
      chk($sformatf("v%0d_wait_ready", idx), {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      chk($sformatf("v%0d_wait_mem_valid", idx), {63'd0, mem_req_valid}, 64'd0);
      if (w == v.wait_cyc) begin
        chk($sformatf("v%0d_resp_ifu", idx), {63'd0, ifu_resp_valid}, {63'd0, ~v.exp_lsu});
        chk($sformatf("v%0d_resp_lsu", idx), {63'd0, lsu_resp_valid}, {63'd0, v.exp_lsu});
        chk($sformatf("v%0d_resp_data", idx),
            {32'd0, (v.exp_lsu ? lsu_rdata : ifu_rdata)}, {32'd0, e_rd});
      end else begin
        chk($sformatf("v%0d_wait_noresp", idx), {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        chk($sformatf("v%0d_wait_busy", idx), {63'd0, busy}, 64'd1);
      end
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    #1;
    chk($sformatf("v%0d_done_busy", idx), {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_valids"}, {59'd0, ifu_req_ready, lsu_req_ready, mem_req_valid,
                           ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({tag, "_mem_w_en"}, {63'd0, mem_w_en}, 64'd0);
    chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_mem_mask"}, {60'd0, mem_mask}, 64'd0);
    chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // table: {ifu_v, ifu_a, lsu_v, lsu_a, lsu_w, wdata, mask, hold, stall, wait, rdata, exp_lsu}
    add_vec(1, 32'h8000_0000, 0, '0, 0, '0, 4'h0, 0, 0, 0, 32'h0010_0093, 0);
    add_vec(1, 32'h8000_0004, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'h1, 0, 0, 0, 32'hFFFF_FFFF, 1);
    add_vec(1, 32'h8000_0004, 0, '0, 0, '0, 4'h0, 0, 0, 0, $urandom(), 0);
    add_vec(0, '0, 1, 32'h8000_2000, 0, '0, 4'hF, 0, 5, 0, $urandom(), 1);
    add_vec(0, '0, 1, 32'h8000_2004, 0, '0, 4'h3, 0, 0, 3, 32'h1234_5678, 1);
    add_vec(1, {$urandom_range(0, 255), 2'b00}, 0, '0, 0, '0, 4'h0, 0,
            $urandom_range(1, 3), $urandom_range(0, 2), $urandom(), 0);
`ifdef MEM_ARBITER_RR_EN
    // both valids held: grants alternate LSU, IFU, LSU, IFU
    add_vec(1, 32'h8000_0010, 1, 32'h8000_3000, 0, '0, 4'hF, 1, 0, 0, $urandom(), 1);
    add_vec(1, 32'h8000_0014, 1, 32'h8000_3004, 0, '0, 4'hF, 1, 0, 0, $urandom(), 0);
    add_vec(1, 32'h8000_0018, 1, 32'h8000_3008, 1, 32'h0BAD_F00D, 4'h3, 1, 1, 1, $urandom(), 1);
    add_vec(1, 32'h8000_001C, 1, 32'h8000_300C, 0, '0, 4'hF, 0, 0, 0, $urandom(), 0);
    // lone LSU after an LSU-last history still wins
    add_vec(0, '0, 1, 32'h8000_300C, 0, '0, 4'hF, 0, 0, 0, $urandom(), 1);
    add_vec(0, '0, 1, 32'h8000_3010, 0, '0, 4'hF, 0, 0, 0, $urandom(), 1);
`else
    // both valids held: LSU keeps winning, IFU only after LSU lets go
    add_vec(1, 32'h8000_0010, 1, 32'h8000_3000, 0, '0, 4'hF, 1, 0, 0, $urandom(), 1);
    add_vec(1, 32'h8000_0010, 1, 32'h8000_3004, 1, 32'h0BAD_F00D, 4'h3, 0, 1, 1, $urandom(), 1);
    add_vec(1, 32'h8000_0010, 0, '0, 0, '0, 4'h0, 0, 0, 0, $urandom(), 0);
`endif

    // reset state
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // spurious response while idle
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      #1;
      chk("idle_spurious_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      chk("idle_spurious_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;

    // reset during WAIT drops the in-flight transaction
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0100;
    #1;
    chk("rst_seq_accept", {63'd0, ifu_req_ready}, 64'd1);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("rst_seq_wait_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1111_1111;
    #1;
    chk("rst_late_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("rst_late_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("rst_after_busy", {63'd0, busy}, 64'd0);

    // normal operation resumes after reset
    begin
      vec_t v;
      v.ifu_v = 1; v.ifu_a = 32'h8000_0200; v.lsu_v = 0; v.lsu_a = '0; v.lsu_w = 0;
      v.wdata = '0; v.mask = '0; v.hold = 0; v.stall = 0; v.wait_cyc = 1;
      v.rdata = 32'h0020_0113; v.exp_lsu = 0;
      run_vec(v, 99);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", {32'd0, exp_q.size()}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
